// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit with HI/LO registers.
//
// Multiply is a shift-add over 32 cycles. Divide is a restoring divide over
// 32 cycles. Signed operations iterate on operand magnitudes, and the signs
// are applied on the final edge. MTHI/MTLO writes land directly in HI/LO
// whenever the unit is not busy.
//
// Build option:
//   MULTDIV_DIV_EN  when defined, the divider datapath is compiled in.
//                   When undefined, DIV/DIVU are accepted but complete on the
//                   next edge and leave HI/LO untouched.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   start    issue request (accepted when not busy)
//   op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rsData   operand A (multiplicand / dividend)
//   rtData   operand B (multiplier / divisor)
//   hiWrite  MTHI request
//   loWrite  MTLO request
//   wrData   MTHI/MTLO data
//   busy     operation in progress
//   done     one-cycle completion pulse
//   hi, lo   result registers
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; MTHI/MTLO accepted
// S_RUN  | one shift-add / restoring-divide iteration per cycle, 32 cycles
// S_DONE | result valid on hi/lo, done=1; start here issues back-to-back

module mult_div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rsData,
   input  logic [XLEN-1:0] rtData,
   input  logic            hiWrite,
   input  logic            loWrite,
   input  logic [XLEN-1:0] wrData,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0]  cnt;
   logic [2*XLEN-1:0] acc, acc_nxt;
   logic [XLEN-1:0]   opb;
   logic              neg_lo;
   logic [XLEN-1:0]   res_hi, res_lo;

   logic              accept, last, run_op;
   logic              a_neg, b_neg;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_nxt, prod_fix;

   assign accept = start && (state != S_RUN);
   assign last   = (state == S_RUN) && (cnt == CNT_W'(XLEN-1));
   assign busy   = (state == S_RUN);
   assign done   = (state == S_DONE);

   // op[0]=0 selects the signed forms (MULT, DIV)
   assign a_neg = ~op[0] & rsData[XLEN-1];
   assign b_neg = ~op[0] & rtData[XLEN-1];
   assign mag_a = a_neg ? -rsData : rsData;
   assign mag_b = b_neg ? -rtData : rtData;

`ifdef MULTDIV_DIV_EN
   assign run_op = 1'b1;
`else
   // without the divider, DIV/DIVU skip RUN entirely
   assign run_op = ~op[1];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_RUN: begin
            if (last) state_nxt = S_DONE;
         end
         S_IDLE, S_DONE: begin
            if (accept)                state_nxt = run_op ? S_RUN : S_DONE;
            else if (state == S_DONE)  state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Multiply: acc = {partial, multiplier}; add multiplicand when lsb set,
   // then shift the 33-bit sum (carry included) back in from the top.
   assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
   assign mul_nxt  = {mul_sum, acc[XLEN-1:1]};
   assign prod_fix = neg_lo ? -acc_nxt : acc_nxt;

`ifdef MULTDIV_DIV_EN
   logic              is_div_q, neg_hi, div0_q;
   logic [XLEN:0]     rem_sh, div_diff;
   logic [2*XLEN-1:0] div_nxt;
   logic [XLEN-1:0]   quot, rem;

   // Divide: acc = {remainder, dividend}; shift one dividend bit into the
   // remainder and keep the trial subtraction when it does not borrow.
   assign rem_sh   = acc[2*XLEN-1:XLEN-1];
   assign div_diff = rem_sh - {1'b0, opb};
   assign div_nxt  = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
   assign acc_nxt  = is_div_q ? div_nxt : mul_nxt;
   assign quot     = acc_nxt[XLEN-1:0];
   assign rem      = acc_nxt[2*XLEN-1:XLEN];

   // A zero divisor never borrows, so the remainder ends up as |dividend|
   // and the sign fix restores the original dividend; only LO is forced.
   // 0x80000000 / -1 falls out naturally: -(0x80000000) wraps to itself.
   always_comb begin
      res_hi = prod_fix[2*XLEN-1:XLEN];
      res_lo = prod_fix[XLEN-1:0];
      if (is_div_q) begin
         res_hi = neg_hi ? -rem : rem;
         res_lo = div0_q ? '1 : (neg_lo ? -quot : quot);
      end
   end
`else
   assign acc_nxt = mul_nxt;

   always_comb begin
      res_hi = prod_fix[2*XLEN-1:XLEN];
      res_lo = prod_fix[XLEN-1:0];
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         acc      <= '0;
         opb      <= '0;
         neg_lo   <= 1'b0;
         hi       <= '0;
         lo       <= '0;
`ifdef MULTDIV_DIV_EN
         is_div_q <= 1'b0;
         neg_hi   <= 1'b0;
         div0_q   <= 1'b0;
`endif
      end else if (state == S_RUN) begin
         cnt <= cnt + CNT_W'(1);
         acc <= acc_nxt;
         if (last) begin
            hi <= res_hi;
            lo <= res_lo;
         end
      end else if (accept) begin
         // start wins over a same-edge MTHI/MTLO
         cnt    <= '0;
         acc    <= {{XLEN{1'b0}}, (op[1] ? mag_a : mag_b)};
         opb    <= op[1] ? mag_b : mag_a;
         neg_lo <= a_neg ^ b_neg;
`ifdef MULTDIV_DIV_EN
         is_div_q <= op[1];
         neg_hi   <= a_neg;
         div0_q   <= (rtData == '0);
`endif
      end else begin
         if (hiWrite) hi <= wrData;
         if (loWrite) lo <= wrData;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rsData, rtData, wrData;
   logic        hiWrite, loWrite;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks   = 0;
   int failures = 0;

   mult_div_unit #(.XLEN(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .rsData  (rsData),
      .rtData  (rtData),
      .hiWrite (hiWrite),
      .loWrite (loWrite),
      .wrData  (wrData),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   // Called at a negedge; returns at the negedge after the accept edge with
   // the operand inputs scrambled so late changes would be visible.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; op = o; rsData = a; rtData = b;
      @(negedge clk);
      start = 1'b0; op = ~o; rsData = 32'hA5A5_5A5A; rtData = 32'h0F0F_F0F0;
   endtask

   // Counts edges until done is seen (bounded) and how many samples had busy.
   task automatic wait_done(output int edges, output int busy_seen);
      edges = 0; busy_seen = 0;
      while (done !== 1'b1 && edges < 100) begin
         if (busy === 1'b1) busy_seen++;
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic test_reset;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=00000000", hi); end
      checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=00000000", lo); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mult_signed;
      int e, b;
      issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
      wait_done(e, b);
      // cycles counted inclusive of the issue cycle
      checks++; if (e + 1 !== 33) begin failures++; $display("FAIL mult_latency got=%0d exp=33", e + 1); end
      checks++; if (b !== 32) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=32", b); end
      checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
      checks++; if (lo !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_lo got=%h exp=ffffffeb", lo); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
   endtask

   task automatic test_back_to_back;
      int e, b;
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(e, b);
      checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
      checks++; if (lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
`ifdef MULTDIV_DIV_EN
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", busy); end
      checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL b2b_hi_hold got=%h exp=fffffffe", hi); end
      wait_done(e, b);
      checks++; if (e + 1 !== 33) begin failures++; $display("FAIL div_latency got=%0d exp=33", e + 1); end
      checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
      checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
`else
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL nodiv_b2b_done got=%b exp=1", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nodiv_b2b_busy got=%b exp=0", busy); end
      checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL nodiv_b2b_hi got=%h exp=fffffffe", hi); end
      checks++; if (lo !== 32'h0000_0001) begin failures++; $display("FAIL nodiv_b2b_lo got=%h exp=00000001", lo); end
`endif
      @(negedge clk);
   endtask

`ifdef MULTDIV_DIV_EN
   task automatic test_div_special;
      int e, b;
      issue(OP_DIVU, 32'd100, 32'd0);
      wait_done(e, b);
      checks++; if (e + 1 !== 33) begin failures++; $display("FAIL div0_latency got=%0d exp=33", e + 1); end
      checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_lo got=%h exp=ffffffff", lo); end
      checks++; if (hi !== 32'd100) begin failures++; $display("FAIL div0_hi got=%h exp=00000064", hi); end
      @(negedge clk);
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(e, b);
      checks++; if (lo !== 32'h8000_0000) begin failures++; $display("FAIL divovf_lo got=%h exp=80000000", lo); end
      checks++; if (hi !== 32'h0) begin failures++; $display("FAIL divovf_hi got=%h exp=00000000", hi); end
      @(negedge clk);
   endtask
`else
   task automatic test_div_disabled;
      issue(OP_DIV, 32'd10, 32'd3);
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL nodiv_done got=%b exp=1", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nodiv_busy got=%b exp=0", busy); end
      checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL nodiv_hi got=%h exp=fffffffe", hi); end
      checks++; if (lo !== 32'h0000_0001) begin failures++; $display("FAIL nodiv_lo got=%h exp=00000001", lo); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL nodiv_done_pulse got=%b exp=0", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nodiv_busy_after got=%b exp=0", busy); end
   endtask
`endif

   task automatic test_busy_ignore;
      int e, b;
      logic [31:0] prev_hi;
`ifdef MULTDIV_DIV_EN
      prev_hi = 32'h0;
`else
      prev_hi = 32'hFFFF_FFFE;
`endif
      issue(OP_MULTU, 32'd5, 32'd6);
      repeat (3) @(negedge clk);
      start = 1'b1; op = OP_MULT; rsData = 32'd7; rtData = 32'd9;
      hiWrite = 1'b1; wrData = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 1'b0; hiWrite = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ign_busy got=%b exp=1", busy); end
      checks++; if (hi !== prev_hi) begin failures++; $display("FAIL ign_mthi got=%h exp=%h", hi, prev_hi); end
      wait_done(e, b);
      checks++; if (e + 5 !== 33) begin failures++; $display("FAIL ign_latency got=%0d exp=33", e + 5); end
      checks++; if (hi !== 32'h0) begin failures++; $display("FAIL ign_hi got=%h exp=00000000", hi); end
      checks++; if (lo !== 32'd30) begin failures++; $display("FAIL ign_lo got=%h exp=0000001e", lo); end
      @(negedge clk);
      loWrite = 1'b1; wrData = 32'h0BAD_F00D;
      @(negedge clk);
      loWrite = 1'b0;
      checks++; if (lo !== 32'h0BAD_F00D) begin failures++; $display("FAIL mtlo_lo got=%h exp=0badf00d", lo); end
      checks++; if (hi !== 32'h0) begin failures++; $display("FAIL mtlo_hi got=%h exp=00000000", hi); end
      hiWrite = 1'b1; loWrite = 1'b1; wrData = 32'h55AA_33CC;
      @(negedge clk);
      hiWrite = 1'b0; loWrite = 1'b0;
      checks++; if (hi !== 32'h55AA_33CC) begin failures++; $display("FAIL mtboth_hi got=%h exp=55aa33cc", hi); end
      checks++; if (lo !== 32'h55AA_33CC) begin failures++; $display("FAIL mtboth_lo got=%h exp=55aa33cc", lo); end
      hiWrite = 1'b1; wrData = 32'hDEAD_0000;
      issue(OP_MULTU, 32'd2, 32'd2);
      hiWrite = 1'b0;
      checks++; if (hi !== 32'h55AA_33CC) begin failures++; $display("FAIL startwins_hi got=%h exp=55aa33cc", hi); end
      wait_done(e, b);
      checks++; if (lo !== 32'd4) begin failures++; $display("FAIL startwins_lo got=%h exp=00000004", lo); end
      checks++; if (hi !== 32'h0) begin failures++; $display("FAIL startwins_res_hi got=%h exp=00000000", hi); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op;
      int e, b;
      hiWrite = 1'b1; wrData = 32'h0000_1234;
      @(negedge clk);
      hiWrite = 1'b0;
      issue(OP_MULT, 32'd1000, 32'd1000);
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
      checks++; if (hi !== 32'h0) begin failures++; $display("FAIL abort_hi got=%h exp=00000000", hi); end
      checks++; if (lo !== 32'h0) begin failures++; $display("FAIL abort_lo got=%h exp=00000000", lo); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      issue(OP_MULT, 32'd2, 32'd3);
      wait_done(e, b);
      checks++; if (e + 1 !== 33) begin failures++; $display("FAIL post_rst_latency got=%0d exp=33", e + 1); end
      checks++; if (lo !== 32'd6) begin failures++; $display("FAIL post_rst_lo got=%h exp=00000006", lo); end
      checks++; if (hi !== 32'h0) begin failures++; $display("FAIL post_rst_hi got=%h exp=00000000", hi); end
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 2'b00;
      rsData = '0; rtData = '0; wrData = '0;
      hiWrite = 1'b0; loWrite = 1'b0;
      repeat (2) @(negedge clk);
      test_reset;
      test_mult_signed;
      test_back_to_back;
`ifdef MULTDIV_DIV_EN
      test_div_special;
`else
      test_div_disabled;
`endif
      test_busy_ignore;
      test_reset_mid_op;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
